// File: rtl/maquina_pkg.sv
// Shared types, price table and recipe tables for the drink-vending controller.
// Recipe durations are in 1-s ticks; a zero entry means the ingredient is not used.
package maquina_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ING_AGUA   = 3'd0,
        ING_CAFE   = 3'd1,
        ING_LECHE  = 3'd2,
        ING_CHOCO  = 3'd3,
        ING_AZUCAR = 3'd4
    } ing_t;

    localparam int N_ING = 5;
    localparam int N_TAB = 4;

    localparam logic [7:0] PRICE [N_TAB] = '{8'd3, 8'd4, 8'd5, 8'd7};

    // Rows are products, columns are {agua, cafe, leche, choco, azucar}
    localparam logic [3:0] RECIPE [N_TAB][N_ING] = '{
        '{4'd1, 4'd2, 4'd0, 4'd0, 4'd1},
        '{4'd1, 4'd1, 4'd2, 4'd0, 4'd1},
        '{4'd0, 4'd0, 4'd2, 4'd2, 4'd1},
        '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1}
    };

    // Products outside the table get an unreachable price
    function automatic logic [7:0] price_of(input logic [7:0] idx);
        logic [7:0] p;
        p = 8'hFF;
        for (int i = 0; i < N_TAB; i++) begin
            if (idx == 8'(i)) p = PRICE[i];
        end
        return p;
    endfunction

    function automatic logic [3:0] dur_of(input logic [7:0] idx, input logic [2:0] ing);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < N_TAB; i++) begin
            for (int k = 0; k < N_ING; k++) begin
                if (idx == 8'(i) && ing == 3'(k)) d = RECIPE[i][k];
            end
        end
        return d;
    endfunction

    // First step at or after 'start' that actually runs; N_ING means the recipe is finished
    function automatic logic [2:0] next_step(input logic [7:0] idx, input logic sugar,
                                             input logic [2:0] start);
        logic [2:0] s;
        logic       found;
        s     = 3'(N_ING);
        found = 1'b0;
        for (int k = 0; k < N_ING; k++) begin
            if (!found && 3'(k) >= start && dur_of(idx, 3'(k)) != 4'd0 &&
                (3'(k) != ING_AZUCAR || sugar)) begin
                s     = 3'(k);
                found = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic [4:0] valve_of(input logic [2:0] s);
        return (s < 3'(N_ING)) ? (5'b00001 << s) : 5'b00000;
    endfunction

endpackage

// File: rtl/maquina_bebidas_param_if.sv
// Coin/selection inputs and valve/display outputs of the vending controller.
interface maquina_bebidas_param_if #(
    parameter int N_PROD   = 4,
    parameter int CREDIT_W = 8
);
    localparam int IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

    logic                coin_100;
    logic                coin_500;
    logic                sel_valid;
    logic [IDX_W-1:0]    sel_idx;
    logic                azucar_sel;
    logic                cancel;
    logic [4:0]          valves;
    logic [CREDIT_W-1:0] display_val;
    logic                busy;
    logic                bebida_lista;
    logic                coin_reject;
    logic                sel_error;

    modport master (
        output coin_100, coin_500, sel_valid, sel_idx, azucar_sel, cancel,
        input  valves, display_val, busy, bebida_lista, coin_reject, sel_error
    );

    modport slave (
        input  coin_100, coin_500, sel_valid, sel_idx, azucar_sel, cancel,
        output valves, display_val, busy, bebida_lista, coin_reject, sel_error
    );
endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle enable every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Prescaler counter and registered wrap pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;
endmodule

// File: rtl/maquina_bebidas_param.sv
// Drink-vending controller: coin credit, selection check, timed valve recipe, change display.
// Optional full refund on cancel when MAQ_REFUND_EN is defined.
module maquina_bebidas_param
    import maquina_pkg::*;
#(
    parameter int N_PROD     = 4,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 11,
    parameter int TICK_DIV   = 50_000_000,
    parameter int CHANGE_TKS = 3
) (
    input logic                    clk,
    input logic                    rst,
    maquina_bebidas_param_if.slave bus
);
    localparam int IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam int CHG_W = (CHANGE_TKS > 1) ? $clog2(CHANGE_TKS) : 1;
    localparam logic [CHG_W-1:0] CHG_LAST = CHG_W'(CHANGE_TKS - 1);
    localparam logic [CREDIT_W:0] MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0] ADD_500 = (CREDIT_W+1)'(5);
    localparam logic [CREDIT_W:0] ADD_100 = (CREDIT_W+1)'(1);

    state_t              state_r;
    logic [CREDIT_W-1:0] credit_r, change_r, display_r;
    logic [IDX_W-1:0]    idx_r;
    logic                sugar_r;
    logic [2:0]          step_r;
    logic [3:0]          timer_r;
    logic [CHG_W-1:0]    chg_tks_r;
    logic [4:0]          valves_r;
    logic                busy_r, lista_r, reject_r, err_r;

    logic                tick_s;
    logic [CREDIT_W:0]   cred_a_s, cred_b_s, price_s;
    logic [CREDIT_W-1:0] credit_nx_s, chg_s;
    logic                acc500_s, acc100_s, coin_rej_s, idx_ok_s, sel_ok_s;
    logic [31:0]         idx_ext_s;
    logic [2:0]          first_step_s, adv_step_s;
    logic [3:0]          cur_dur_s;
    logic                step_done_s, finish_s;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst),
        .tick  (tick_s)
    );

    // Coin acceptance (500 first), selection validation and next-step search
    always_comb begin
        cred_a_s = {1'b0, credit_r};
        if (bus.coin_500 && (cred_a_s + ADD_500) <= MAX_C) begin
            acc500_s = 1'b1;
            cred_a_s = cred_a_s + ADD_500;
        end else begin
            acc500_s = 1'b0;
        end
        cred_b_s = cred_a_s;
        if (bus.coin_100 && (cred_a_s + ADD_100) <= MAX_C) begin
            acc100_s = 1'b1;
            cred_b_s = cred_a_s + ADD_100;
        end else begin
            acc100_s = 1'b0;
        end
        coin_rej_s   = (bus.coin_500 && !acc500_s) || (bus.coin_100 && !acc100_s);
        credit_nx_s  = cred_b_s[CREDIT_W-1:0];
        idx_ext_s    = 32'(bus.sel_idx);
        idx_ok_s     = idx_ext_s < 32'(N_PROD);
        price_s      = (CREDIT_W+1)'(price_of(8'(bus.sel_idx)));
        sel_ok_s     = idx_ok_s && (cred_b_s >= price_s);
        chg_s        = credit_nx_s - price_s[CREDIT_W-1:0];
        first_step_s = next_step(8'(bus.sel_idx), bus.azucar_sel, 3'd0);
        adv_step_s   = next_step(8'(idx_r), sugar_r, step_r + 3'd1);
        cur_dur_s    = dur_of(8'(idx_r), step_r);
        step_done_s  = tick_s && (timer_r == cur_dur_s - 4'd1);
        finish_s     = (step_r >= 3'(N_ING)) || (step_done_s && adv_step_s >= 3'(N_ING));
    end

`ifndef MAQ_REFUND_EN
    logic unused_cancel_s;
    assign unused_cancel_s = bus.cancel;
`endif

    // Main FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            credit_r  <= {CREDIT_W{1'b0}};
            change_r  <= {CREDIT_W{1'b0}};
            display_r <= {CREDIT_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            sugar_r   <= 1'b0;
            step_r    <= 3'd0;
            timer_r   <= 4'd0;
            chg_tks_r <= {CHG_W{1'b0}};
            valves_r  <= 5'b00000;
            busy_r    <= 1'b0;
            lista_r   <= 1'b0;
            reject_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            lista_r  <= 1'b0;
            err_r    <= 1'b0;
            reject_r <= bus.coin_100 | bus.coin_500;
            case (state_r)
                IDLE: begin
                    reject_r <= coin_rej_s;
                    credit_r <= credit_nx_s;
`ifdef MAQ_REFUND_EN
                    if (bus.cancel && credit_nx_s != {CREDIT_W{1'b0}}) begin
                        state_r   <= CHANGE;
                        change_r  <= credit_nx_s;
                        display_r <= credit_nx_s;
                        chg_tks_r <= {CHG_W{1'b0}};
                        valves_r  <= 5'b00000;
                        busy_r    <= 1'b1;
                    end else
`endif
                    if (bus.sel_valid && sel_ok_s) begin
                        state_r   <= DISPENSE;
                        idx_r     <= bus.sel_idx;
                        sugar_r   <= bus.azucar_sel;
                        step_r    <= first_step_s;
                        timer_r   <= 4'd0;
                        change_r  <= chg_s;
                        valves_r  <= valve_of(first_step_s);
                        display_r <= {CREDIT_W{1'b0}};
                        busy_r    <= 1'b1;
                    end else begin
                        err_r     <= bus.sel_valid;
                        display_r <= credit_nx_s;
                        valves_r  <= 5'b00000;
                        busy_r    <= 1'b0;
                    end
                end
                DISPENSE: begin
                    display_r <= {CREDIT_W{1'b0}};
                    if (finish_s) begin
                        state_r   <= CHANGE;
                        lista_r   <= 1'b1;
                        valves_r  <= 5'b00000;
                        display_r <= change_r;
                        chg_tks_r <= {CHG_W{1'b0}};
                    end else if (step_done_s) begin
                        step_r   <= adv_step_s;
                        timer_r  <= 4'd0;
                        valves_r <= valve_of(adv_step_s);
                    end else if (tick_s) begin
                        timer_r <= timer_r + 4'd1;
                    end else begin
                        timer_r <= timer_r;
                    end
                end
                CHANGE: begin
                    valves_r <= 5'b00000;
                    if (tick_s && chg_tks_r == CHG_LAST) begin
                        state_r   <= IDLE;
                        credit_r  <= {CREDIT_W{1'b0}};
                        display_r <= {CREDIT_W{1'b0}};
                        busy_r    <= 1'b0;
                    end else if (tick_s) begin
                        chg_tks_r <= chg_tks_r + CHG_W'(1);
                        display_r <= change_r;
                    end else begin
                        display_r <= change_r;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    valves_r  <= 5'b00000;
                    display_r <= {CREDIT_W{1'b0}};
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valves       = valves_r;
    assign bus.display_val  = display_r;
    assign bus.busy         = busy_r;
    assign bus.bebida_lista = lista_r;
    assign bus.coin_reject  = reject_r;
    assign bus.sel_error    = err_r;
endmodule

// File: tb/tb_maquina_bebidas_param.sv
// Directed bench for maquina_bebidas_param (TICK_DIV=4, CHANGE_TKS=3, default tables).
module tb_maquina_bebidas_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    maquina_bebidas_param_if #(.N_PROD(4), .CREDIT_W(8)) bus0 ();
    maquina_bebidas_param_if #(.N_PROD(3), .CREDIT_W(8)) bus1 ();

    maquina_bebidas_param #(.N_PROD(4), .CREDIT_W(8), .MAX_CREDIT(11), .TICK_DIV(4), .CHANGE_TKS(3))
        dut (.clk(clk), .rst(rst), .bus(bus0));
    maquina_bebidas_param #(.N_PROD(3), .CREDIT_W(8), .MAX_CREDIT(11), .TICK_DIV(4), .CHANGE_TKS(3))
        dut3 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic       rst_pre;
        logic       c100;
        logic       c500;
        logic       sv;
        logic [1:0] idx;
        logic       azu;
        logic [7:0] e_disp;
        logic       e_busy;
        logic       e_rej;
        logic       e_err;
    } vec_t;

    vec_t       vecs [17];
    logic [4:0] exp_v [5];
    int         exp_d [5];

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, id, act, req);
        end
    endtask

    task automatic chk_rng(input string nm, input int id, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d want=%0d..%0d", nm, id, act, lo, hi);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic apply(input logic c100, input logic c500, input logic sv, input logic [1:0] idx,
                         input logic azu, input logic cnc);
        bus0.coin_100 = c100; bus0.coin_500 = c500; bus0.sel_valid = sv;
        bus0.sel_idx = idx; bus0.azucar_sel = azu; bus0.cancel = cnc;
        @(negedge clk);
        bus0.coin_100 = 1'b0; bus0.coin_500 = 1'b0; bus0.sel_valid = 1'b0;
        bus0.sel_idx = 2'd0; bus0.azucar_sel = 1'b0; bus0.cancel = 1'b0;
    endtask

    // Called at the first CHANGE sample; follows the display until IDLE
    task automatic watch_change(input logic [7:0] echg, input int id);
        int hold;
        bit bad;
        hold = 1;
        bad  = 1'b0;
        chk("chg_disp", id, bus0.display_val, echg);
        chk("chg_busy", id, bus0.busy, 1);
        for (int c = 0; c < 40 && bus0.busy; c++) begin
            @(negedge clk);
            if (bus0.busy) begin
                hold++;
                if (bus0.display_val !== echg || bus0.bebida_lista !== 1'b0) bad = 1'b1;
            end
        end
        chk("chg_steady", id, bad, 0);
        chk_rng("chg_len", id, hold, 9, 12);
        chk("idle_busy", id, bus0.busy, 0);
        chk("idle_disp", id, bus0.display_val, 0);
    endtask

    // Called at the first DISPENSE sample; records valve runs until bebida_lista
    task automatic watch_dispense(input int n, input logic [7:0] echg, input int id);
        logic [4:0] rv [8];
        int         rl [8];
        int         nrun, cnt;
        logic [4:0] cur;
        bit         seen;
        nrun = 0; cnt = 1; seen = 1'b0;
        cur  = bus0.valves;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus0.bebida_lista || bus0.valves != cur) begin
                if (nrun < 8) begin
                    rv[nrun] = cur;
                    rl[nrun] = cnt;
                end
                nrun++;
                cur  = bus0.valves;
                cnt  = 1;
                seen = bus0.bebida_lista;
            end else begin
                cnt++;
            end
        end
        chk("lista_seen", id, seen, 1);
        chk("lista_valves", id, bus0.valves, 0);
        chk("n_steps", id, nrun, n);
        for (int i = 0; i < n && i < nrun && i < 5; i++) begin
            chk("step_valve", id * 10 + i, rv[i], exp_v[i]);
            if (i == 0) chk_rng("step_len", id * 10 + i, rl[i], 4 * (exp_d[i] - 1) + 1, 4 * exp_d[i]);
            else        chk("step_len", id * 10 + i, rl[i], 4 * exp_d[i]);
        end
        watch_change(echg, id);
    endtask

    initial begin
        bus0.coin_100 = 1'b0; bus0.coin_500 = 1'b0; bus0.sel_valid = 1'b0;
        bus0.sel_idx = 2'd0; bus0.azucar_sel = 1'b0; bus0.cancel = 1'b0;
        bus1.coin_100 = 1'b0; bus1.coin_500 = 1'b0; bus1.sel_valid = 1'b0;
        bus1.sel_idx = 2'd0; bus1.azucar_sel = 1'b0; bus1.cancel = 1'b0;

        //         rst   c100  c500  sv    idx   azu   disp   busy  rej   err
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd5,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd10, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd11, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd11, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd11, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd1,  1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd2,  1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd3,  1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd4,  1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 8'd4,  1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd4,  1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 8'd4,  1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 8'd0,  1'b1, 1'b0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].rst_pre) do_reset();
            apply(vecs[i].c100, vecs[i].c500, vecs[i].sv, vecs[i].idx, vecs[i].azu, 1'b0);
            chk("vec", i,
                {bus0.display_val, bus0.busy, bus0.coin_reject, bus0.sel_error},
                {vecs[i].e_disp, vecs[i].e_busy, vecs[i].e_rej, vecs[i].e_err});
        end

        // Product 2 is now dispensing leche; coins rejected, then async reset mid-step
        chk("disp_first_valve", 0, bus0.valves, 5'b00100);
        apply(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("disp_coin_rej", 0, bus0.coin_reject, 1);
        chk("disp_busy", 0, bus0.busy, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_valves", 0, bus0.valves, 0);
        chk("rst_busy", 0, bus0.busy, 0);
        chk("rst_disp", 0, bus0.display_val, 0);
        @(negedge clk);
        rst = 1'b1;

        // 500 + 100, product 0 with sugar: agua 1, cafe 2, azucar 1, change 3
        apply(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("seqA_credit", 1, bus0.display_val, 6);
        apply(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
        chk("seqA_busy", 1, bus0.busy, 1);
        chk("seqA_valve0", 1, bus0.valves, 5'b00001);
        exp_v[0] = 5'b00001; exp_d[0] = 1;
        exp_v[1] = 5'b00010; exp_d[1] = 2;
        exp_v[2] = 5'b10000; exp_d[2] = 1;
        watch_dispense(3, 8'd3, 1);

        // Credit 2, coin_100 and selection in the same cycle, no sugar, change 0
        apply(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("seqB_credit", 2, bus0.display_val, 2);
        apply(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        chk("seqB_busy", 2, bus0.busy, 1);
        chk("seqB_err", 2, bus0.sel_error, 0);
        exp_v[0] = 5'b00001; exp_d[0] = 1;
        exp_v[1] = 5'b00010; exp_d[1] = 2;
        watch_dispense(2, 8'd0, 2);

        // Both coins accepted in one cycle, then cancel
        apply(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("seqC_credit", 3, bus0.display_val, 6);
        chk("seqC_rej", 3, bus0.coin_reject, 0);
        apply(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
`ifdef MAQ_REFUND_EN
        watch_change(8'd6, 3);
`else
        chk("seqC_ignored_busy", 3, bus0.busy, 0);
        chk("seqC_ignored_disp", 3, bus0.display_val, 6);
        apply(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("seqC_kept", 3, bus0.display_val, 6);
`endif

        // Three-product instance: index 3 is out of range
        bus1.coin_500 = 1'b1;
        @(negedge clk);
        bus1.coin_500 = 1'b0;
        chk("p3_credit", 4, bus1.display_val, 5);
        bus1.sel_valid = 1'b1;
        bus1.sel_idx   = 2'd3;
        @(negedge clk);
        bus1.sel_valid = 1'b0;
        chk("p3_bad_idx_err", 4, bus1.sel_error, 1);
        chk("p3_bad_idx_state", 4, {bus1.busy, bus1.display_val}, {1'b0, 8'd5});
        bus1.sel_valid = 1'b1;
        bus1.sel_idx   = 2'd2;
        @(negedge clk);
        bus1.sel_valid = 1'b0;
        bus1.sel_idx   = 2'd0;
        chk("p3_good_idx", 4, {bus1.busy, bus1.sel_error}, {1'b1, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
